// File: rtl/noc_vc_grant_arbiter_pkg.sv
// Shared types and constants for the VC grant arbiter and the rotating-priority picker.
package noc_vc_grant_arbiter_pkg;

    localparam int Noc_VC_Channel   = 4;
    localparam int Noc_VC_Idx_Width = $clog2(Noc_VC_Channel);

    typedef enum logic [1:0] {
        BODY     = 2'd0,
        HEAD     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } Noc_flit_type_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } Noc_vc_arb_state_e;

    function automatic logic flit_opens_packet(input Noc_flit_type_e t);
        return (t == HEAD) || (t == HEADTAIL);
    endfunction

    function automatic logic flit_closes_packet(input Noc_flit_type_e t);
        return (t == TAIL) || (t == HEADTAIL);
    endfunction

endpackage

// File: rtl/noc_vc_grant_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set req bit at or after ptr, wrapping at CHANNELS.
module noc_rr_pick
    import noc_vc_grant_arbiter_pkg::*;
#(
    parameter int CHANNELS = Noc_VC_Channel,
    parameter int IDX_W    = Noc_VC_Idx_Width
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [CHANNELS-1:0] onehot,
    output logic [IDX_W-1:0]    idx,
    output logic                found
);

    logic [IDX_W:0] cand;

    // One spare bit holds ptr+k before the wrap, so non-power-of-two sizes wrap by compare.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(CHANNELS)) begin
                cand = cand - (IDX_W+1)'(CHANNELS);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                onehot[cand[IDX_W-1:0]] = 1'b1;
                idx                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/noc_vc_grant_arbiter.sv
// Packet-locked round-robin VC grant arbiter feeding the VC merge stage.
// Optional stall watchdog enabled by defining NOC_VC_ARB_WATCHDOG_EN.
//
//   state      | meaning
//   ARB_IDLE   | no grant; picks next packet head in round-robin order
//   ARB_LOCKED | grant held on one VC until its tail flit transfers
module noc_vc_grant_arbiter
    import noc_vc_grant_arbiter_pkg::*;
#(
    parameter int CHANNELS    = Noc_VC_Channel,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                        noc_clk,
    input  logic                        noc_rst_n,
    input  logic [CHANNELS-1:0]         i_vc_valid,
    input  logic [2*CHANNELS-1:0]       i_vc_flit_type,
    input  logic                        i_out_ready,
    input  logic                        i_out_almost_full,
    output logic [CHANNELS-1:0]         o_vc_grant,
    output logic [$clog2(CHANNELS)-1:0] o_grant_idx,
    output logic                        o_grant_active,
    output logic                        o_wdog_err
);

    localparam int IW = $clog2(CHANNELS);

    if (CHANNELS < 2 || WDOG_CYCLES < 2) begin : g_param_check
        $error("noc_vc_grant_arbiter: CHANNELS and WDOG_CYCLES must be >= 2");
    end

    Noc_vc_arb_state_e   state_q, state_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;

    logic [CHANNELS-1:0] eligible;
    logic [CHANNELS-1:0] pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_found;
    Noc_flit_type_e      cur_type;
    logic                cur_valid;
    logic                xfer;
    logic                wdog_fire;
    logic [IW-1:0]       ptr_after_cur;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            eligible[i] = i_vc_valid[i] &
                          flit_opens_packet(Noc_flit_type_e'(i_vc_flit_type[2*i +: 2]));
        end
    end

    noc_rr_pick #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IW)
    ) u_pick (
        .req    (eligible),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        cur_type  = BODY;
        cur_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_type  = Noc_flit_type_e'(i_vc_flit_type[2*i +: 2]);
                cur_valid = i_vc_valid[i];
            end
        end
    end

    assign xfer          = (state_q == ARB_LOCKED) & cur_valid & i_out_ready;
    assign ptr_after_cur = (idx_q == IW'(CHANNELS-1)) ? '0 : idx_q + IW'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found && !i_out_almost_full) begin
                    state_d = ARB_LOCKED;
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                end
            end
            ARB_LOCKED: begin
                if ((xfer && flit_closes_packet(cur_type)) || wdog_fire) begin
                    state_d  = ARB_IDLE;
                    grant_d  = '0;
                    idx_d    = '0;
                    rr_ptr_d = ptr_after_cur;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef NOC_VC_ARB_WATCHDOG_EN
    localparam int                CW        = $clog2(WDOG_CYCLES);
    localparam logic [CW-1:0]     WDOG_LOAD = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_err_q, wdog_err_d;

    // Down-counter reloads on every transfer and while idle; expiry is terminal count zero.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (state_q != ARB_LOCKED || xfer) begin
            wdog_cnt_d = WDOG_LOAD;
        end else if (wdog_cnt_q != '0) begin
            wdog_cnt_d = wdog_cnt_q - CW'(1);
        end
        wdog_err_d = wdog_err_q | wdog_fire;
    end

    assign wdog_fire = (state_q == ARB_LOCKED) && !xfer && (wdog_cnt_q == '0);

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            wdog_cnt_q <= WDOG_LOAD;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign o_wdog_err = wdog_err_q;
`else
    assign wdog_fire  = 1'b0;
    assign o_wdog_err = 1'b0;
`endif

    assign o_vc_grant     = grant_q;
    assign o_grant_idx    = idx_q;
    assign o_grant_active = (state_q == ARB_LOCKED);

    a_grant_onehot0: assert property (@(posedge noc_clk) $onehot0(o_vc_grant));
    a_active_match:  assert property (@(posedge noc_clk) o_grant_active == (|o_vc_grant));

endmodule
